conv2_sched: RTL and testbench

CONV2_SCHED -- requirements
Module: conv2_sched

---
 rtl/conv2_pkg.sv | 37 +++
 rtl/conv2_bias_sat.sv | 30 +++
 rtl/conv2_sched.sv | 176 +++++++++++++++++
 tb/tb_conv2_sched.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv2_pkg.sv
// conv2_pkg: shared types and constants for the conv2 window scheduler.
// Holds the FSM state encoding, width/filter-count defaults and the
// per-filter bias table used by the shared calc unit results.
package conv2_pkg;

   localparam int DW_DEF     = 14;
   localparam int N_FILT_DEF = 3;

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_WAIT_WIN  = 3'd1,
      S_ISSUE     = 3'd2,
      S_WAIT_CALC = 3'd3,
      S_EMIT      = 3'd4,
      S_FINISH    = 3'd5
   } state_e;

   // Per-filter bias, signed, indexed by filter number.
   localparam logic signed [DW_DEF-1:0] BIAS [N_FILT_DEF] = '{default: '0};

   // Flattens the bias table so it can travel as a packed module parameter;
   // filter i lives in bits [i*DW_DEF +: DW_DEF].
   function automatic logic [N_FILT_DEF*DW_DEF-1:0] bias_pack();
      logic [N_FILT_DEF*DW_DEF-1:0] v;
      v = '0;
      for (int i = 0; i < N_FILT_DEF; i++) begin
         v[i*DW_DEF +: DW_DEF] = BIAS[i];
      end
      return v;
   endfunction

   // Counter width that stays at least one bit for degenerate sizes.
   function automatic int cnt_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/conv2_bias_sat.sv
// conv2_bias_sat: adds the filter bias to a calc result one bit wider than
// the operands, then saturates back to DW signed bits.
// Optional feature: CONV2_SCHED_RELU_EN clamps negative results to zero.
module conv2_bias_sat #(
   parameter int DW = 14
) (
   input  logic signed [DW-1:0] calc_val,
   input  logic signed [DW-1:0] bias,
   output logic signed [DW-1:0] result
);

   logic [DW:0]   sum;
   logic [DW-1:0] sat;

   // Sign-extended add, saturate on overflow (top two sum bits disagree).
   always_comb begin
      sum = {calc_val[DW-1], calc_val} + {bias[DW-1], bias};
      if (sum[DW] != sum[DW-1]) begin
         sat = sum[DW] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
      end else begin
         sat = sum[DW-1:0];
      end
`ifdef CONV2_SCHED_RELU_EN
      result = sat[DW-1] ? '0 : sat;
`else
      result = sat;
`endif
   end

endmodule

// File: rtl/conv2_sched.sv
// conv2_sched: walks every output window position of a feature map
// (row-major, filter innermost), launches one shared calc per filter set,
// captures the result, and emits it biased and saturated.
// Optional feature: CONV2_SCHED_RELU_EN (ReLU on emitted data, in conv2_bias_sat).
//
// state       | meaning
// ------------+------------------------------------------------------------
// S_IDLE      | no pass running; waits for start
// S_WAIT_WIN  | waits for the window buffer to hold (row, col)
// S_ISSUE     | one-cycle calc_go for the current window and filter
// S_WAIT_CALC | waits for calc_valid; captures calc_in
// S_EMIT      | one-cycle out_valid; then next filter or next window
// S_FINISH    | one-cycle done pulse, busy already low
module conv2_sched import conv2_pkg::*; #(
   parameter int OUT_DIM = 8,
   parameter int N_FILT  = N_FILT_DEF,
   parameter int DW      = DW_DEF,
   parameter logic [N_FILT*DW-1:0] BIAS_VEC = (N_FILT*DW)'(bias_pack()),
   localparam int RW = cnt_w(OUT_DIM),
   localparam int FW = cnt_w(N_FILT)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic                 win_ready,
   input  logic signed [DW-1:0] calc_in,
   input  logic                 calc_valid,
   output logic [RW-1:0]        win_row,
   output logic [RW-1:0]        win_col,
   output logic [FW-1:0]        filt_sel,
   output logic                 calc_go,
   output logic signed [DW-1:0] out_data,
   output logic [FW-1:0]        out_ch,
   output logic                 out_valid,
   output logic                 busy,
   output logic                 done
);

   localparam logic [RW-1:0] POS_LAST  = RW'(OUT_DIM - 1);
   localparam logic [FW-1:0] FILT_LAST = FW'(N_FILT - 1);

   state_e                state_q, state_d;
   logic [RW-1:0]         row_q, row_d;
   logic [RW-1:0]         col_q, col_d;
   logic [FW-1:0]         filt_q, filt_d;
   logic signed [DW-1:0]  cap_q, cap_d;
   logic signed [DW-1:0]  bias_sel;
   logic signed [DW-1:0]  sat_res;

   // State and counter registers; synchronous reset aborts any pass.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         row_q   <= '0;
         col_q   <= '0;
         filt_q  <= '0;
         cap_q   <= '0;
      end else begin
         state_q <= state_d;
         row_q   <= row_d;
         col_q   <= col_d;
         filt_q  <= filt_d;
         cap_q   <= cap_d;
      end
   end

   // Next state, window/filter counters and result capture.
   always_comb begin
      state_d = state_q;
      row_d   = row_q;
      col_d   = col_q;
      filt_d  = filt_q;
      cap_d   = cap_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_WAIT_WIN;
               row_d   = '0;
               col_d   = '0;
               filt_d  = '0;
            end
         end
         S_WAIT_WIN: begin
            if (win_ready) state_d = S_ISSUE;
         end
         S_ISSUE: begin
            state_d = S_WAIT_CALC;
         end
         S_WAIT_CALC: begin
            if (calc_valid) begin
               state_d = S_EMIT;
               cap_d   = calc_in;
            end
         end
         S_EMIT: begin
            if (filt_q != FILT_LAST) begin
               // Same window, next filter set: no new win_ready handshake.
               filt_d  = filt_q + 1'b1;
               state_d = S_ISSUE;
            end else begin
               filt_d  = '0;
               state_d = S_WAIT_WIN;
               if (col_q != POS_LAST) begin
                  col_d = col_q + 1'b1;
               end else begin
                  col_d = '0;
                  if (row_q != POS_LAST) begin
                     row_d = row_q + 1'b1;
                  end else begin
                     row_d   = '0;
                     state_d = S_FINISH;
                  end
               end
            end
         end
         S_FINISH: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Bias lookup for the filter currently being emitted.
   always_comb begin
      bias_sel = '0;
      for (int i = 0; i < N_FILT; i++) begin
         if (filt_q == FW'(i)) bias_sel = BIAS_VEC[i*DW +: DW];
      end
   end

   conv2_bias_sat #(
      .DW (DW)
   ) u_bias_sat (
      .calc_val (cap_q),
      .bias     (bias_sel),
      .result   (sat_res)
   );

   // Moore outputs decoded from the current state.
   always_comb begin
      busy      = 1'b0;
      done      = 1'b0;
      calc_go   = 1'b0;
      out_valid = 1'b0;
      out_data  = '0;
      out_ch    = '0;
      case (state_q)
         S_WAIT_WIN, S_WAIT_CALC: begin
            busy = 1'b1;
         end
         S_ISSUE: begin
            busy    = 1'b1;
            calc_go = 1'b1;
         end
         S_EMIT: begin
            busy      = 1'b1;
            out_valid = 1'b1;
            out_data  = sat_res;
            out_ch    = filt_q;
         end
         S_FINISH: begin
            done = 1'b1;
         end
         default: begin
            busy = 1'b0;
         end
      endcase
   end

   assign win_row  = row_q;
   assign win_col  = col_q;
   assign filt_sel = filt_q;

endmodule

// File: tb/tb_conv2_sched.sv
// tb_conv2_sched: directed bench for conv2_sched. Three instances share clk:
// u_a defaults (8x8, 3 filters, zero bias), u_b 2x2 with biases -5/+5/-5
// for saturation, u_c 2x2 single filter for ordering.
module tb_conv2_sched;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string tag, input logic signed [63:0] obs,
                      input logic signed [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // ---------------- instance A: defaults ----------------
   logic               rst_a, start_a, wr_a, cv_a, go_a, ov_a, busy_a, done_a;
   logic signed [13:0] ci_a, od_a;
   logic [2:0]         row_a, col_a;
   logic [1:0]         fsel_a, och_a;

   conv2_sched #(.OUT_DIM(8)) u_a (
      .clk(clk), .rst(rst_a), .start(start_a), .win_ready(wr_a),
      .calc_in(ci_a), .calc_valid(cv_a), .win_row(row_a), .win_col(col_a),
      .filt_sel(fsel_a), .calc_go(go_a), .out_data(od_a), .out_ch(och_a),
      .out_valid(ov_a), .busy(busy_a), .done(done_a)
   );

   // ---------------- instance B: bias/saturation ----------------
   logic               rst_bc, start_bc, wr_bc, cv_b, go_b, ov_b, busy_b, done_b;
   logic signed [13:0] ci_b, od_b;
   logic [0:0]         row_b, col_b;
   logic [1:0]         fsel_b, och_b;

   conv2_sched #(.OUT_DIM(2), .N_FILT(3), .DW(14),
                 .BIAS_VEC({14'h3FFB, 14'h0005, 14'h3FFB})) u_b (
      .clk(clk), .rst(rst_bc), .start(start_bc), .win_ready(wr_bc),
      .calc_in(ci_b), .calc_valid(cv_b), .win_row(row_b), .win_col(col_b),
      .filt_sel(fsel_b), .calc_go(go_b), .out_data(od_b), .out_ch(och_b),
      .out_valid(ov_b), .busy(busy_b), .done(done_b)
   );

   // ---------------- instance C: 2x2, one filter ----------------
   logic               cv_c, go_c, ov_c, busy_c, done_c;
   logic signed [13:0] ci_c, od_c;
   logic [0:0]         row_c, col_c, fsel_c, och_c;

   conv2_sched #(.OUT_DIM(2), .N_FILT(1)) u_c (
      .clk(clk), .rst(rst_bc), .start(start_bc), .win_ready(wr_bc),
      .calc_in(ci_c), .calc_valid(cv_c), .win_row(row_c), .win_col(col_c),
      .filt_sel(fsel_c), .calc_go(go_c), .out_data(od_c), .out_ch(och_c),
      .out_valid(ov_c), .busy(busy_c), .done(done_c)
   );

   // Raw calc value returned by the B model for a window/filter.
   function automatic int raw_b(input int r, input int c, input int f);
      if (r == 0) return (c == 0) ? ((f == 1) ? 8191 : -8192) : 100;
      return (c == 0) ? -100 : 0;
   endfunction

   function automatic int exp_b(input int r, input int c, input int f);
      int s;
      s = raw_b(r, c, f) + ((f == 1) ? 5 : -5);
      if (s > 8191) s = 8191;
      if (s < -8192) s = -8192;
`ifdef CONV2_SCHED_RELU_EN
      if (s < 0) s = 0;
`endif
      return s;
   endfunction

   // Calc unit models: result valid two cycles after calc_go.
   initial begin : calc_model_a
      int dly;
      dly = 0; cv_a = 1'b0; ci_a = 14'sd10;
      forever begin
         @(posedge clk); #1;
         cv_a = 1'b0;
         if (dly > 0) begin dly--; if (dly == 0) cv_a = 1'b1; end
         if (go_a) dly = 2;
      end
   end

   initial begin : calc_model_b
      int dly;
      dly = 0; cv_b = 1'b0; ci_b = '0;
      forever begin
         @(posedge clk); #1;
         cv_b = 1'b0;
         if (dly > 0) begin dly--; if (dly == 0) cv_b = 1'b1; end
         if (go_b) begin dly = 2; ci_b = 14'(raw_b(int'(row_b), int'(col_b), int'(fsel_b))); end
      end
   end

   initial begin : calc_model_c
      int dly;
      dly = 0; cv_c = 1'b0; ci_c = '0;
      forever begin
         @(posedge clk); #1;
         cv_c = 1'b0;
         if (dly > 0) begin dly--; if (dly == 0) cv_c = 1'b1; end
         if (go_c) begin dly = 2; ci_c = 14'(int'(row_c) * 2 + int'(col_c) + 1); end
      end
   end

   // Scoreboards: expected (row, col, filt) of the next result per instance.
   int er_a = 0, ec_a = 0, ef_a = 0, n_ov_a = 0, n_done_a = 0;
   int er_b = 0, ec_b = 0, ef_b = 0, n_ov_b = 0, n_done_b = 0;
   int er_c = 0, ec_c = 0, n_ov_c = 0, n_done_c = 0;
   logic prev_ov_c = 1'b0;

   initial begin : mon_a
      forever begin
         @(negedge clk);
         if (ov_a) begin
            chk("a_pos", row_a * 100 + col_a * 10 + och_a, er_a * 100 + ec_a * 10 + ef_a);
            chk("a_data", od_a, 10);
            n_ov_a++;
            if (ef_a < 2) ef_a++;
            else begin ef_a = 0; if (ec_a < 7) ec_a++; else begin ec_a = 0; er_a++; end end
         end
         if (done_a) begin
            n_done_a++;
            chk("a_busy_at_done", busy_a, 0);
         end
      end
   end

   initial begin : mon_b
      forever begin
         @(negedge clk);
         if (ov_b) begin
            chk("b_pos", row_b * 100 + col_b * 10 + och_b, er_b * 100 + ec_b * 10 + ef_b);
            chk("b_data", od_b, exp_b(er_b, ec_b, ef_b));
            n_ov_b++;
            if (ef_b < 2) ef_b++;
            else begin ef_b = 0; if (ec_b < 1) ec_b++; else begin ec_b = 0; er_b++; end end
         end
         if (done_b) n_done_b++;
      end
   end

   initial begin : mon_c
      forever begin
         @(negedge clk);
         if (ov_c) begin
            chk("c_pos", row_c * 10 + col_c, er_c * 10 + ec_c);
            chk("c_data", od_c, er_c * 2 + ec_c + 1);
            n_ov_c++;
            if (ec_c < 1) ec_c++; else begin ec_c = 0; er_c++; end
         end
         if (done_c) begin
            n_done_c++;
            chk("c_done_after_4", n_ov_c, 4);
            chk("c_done_follows_emit", prev_ov_c, 1);
         end
         prev_ov_c = ov_c;
      end
   end

   task automatic chk_idle_a(input string pfx);
      chk({pfx, "_busy"}, busy_a, 0);
      chk({pfx, "_done"}, done_a, 0);
      chk({pfx, "_calc_go"}, go_a, 0);
      chk({pfx, "_out_valid"}, ov_a, 0);
      chk({pfx, "_out_data"}, od_a, 0);
      chk({pfx, "_out_ch"}, och_a, 0);
      chk({pfx, "_win_row"}, row_a, 0);
      chk({pfx, "_win_col"}, col_a, 0);
      chk({pfx, "_filt_sel"}, fsel_a, 0);
   endtask

   initial begin : main
      int cyc, stall, go_stall, t_enter, snap;
      bit fin, got_resume, hit;

      rst_a = 1'b1; rst_bc = 1'b1; start_a = 1'b0; start_bc = 1'b0;
      wr_a = 1'b1; wr_bc = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk_idle_a("reset");
      rst_a = 1'b0; rst_bc = 1'b0;
      @(posedge clk); #1;

      // Pass 1 on A (with a col-3 stall and a start while busy), B and C in parallel.
      start_a = 1'b1; start_bc = 1'b1;
      @(posedge clk); #1;
      start_a = 1'b0; start_bc = 1'b0;
      chk("a_busy_after_start", busy_a, 1);
      chk("a_start_pos", row_a * 100 + col_a * 10 + fsel_a, 0);

      cyc = 0; stall = 0; go_stall = 0; t_enter = -1; fin = 0; got_resume = 0;
      while (!fin && cyc < 5000) begin
         if (row_a == 0 && col_a == 3 && t_enter < 0) t_enter = cyc;
         if (go_a && row_a == 0 && col_a == 3 && !got_resume) begin
            got_resume = 1;
            chk("a_stall_len", cyc - t_enter, 21);
            chk("a_resume_filt", fsel_a, 0);
         end
         if (row_a == 0 && col_a == 3 && stall < 20) begin
            wr_a = 1'b0;
            stall++;
            if (go_a) go_stall++;
         end else begin
            wr_a = 1'b1;
         end
         start_a = (cyc == 100) || done_a;
         if (done_a) fin = 1;
         else begin @(posedge clk); #1; cyc++; end
      end
      chk("a_pass1_done_seen", fin, 1);
      chk("a_go_during_stall", go_stall, 0);
      chk("a_resume_seen", got_resume, 1);
      @(posedge clk); #1;
      start_a = 1'b0;
      chk("a_start_in_finish_ignored", busy_a, 0);
      repeat (10) @(posedge clk);
      #1;
      chk("a_still_idle", busy_a, 0);
      chk("a_pass1_results", n_ov_a, 192);
      chk("a_pass1_done_count", n_done_a, 1);
      chk("b_results", n_ov_b, 12);
      chk("b_done_count", n_done_b, 1);
      chk("c_results", n_ov_c, 4);
      chk("c_done_count", n_done_c, 1);

      // Pass 2: abort with reset in WAIT_CALC at (4, 2, 1).
      er_a = 0; ec_a = 0; ef_a = 0; n_ov_a = 0; n_done_a = 0;
      start_a = 1'b1;
      @(posedge clk); #1;
      start_a = 1'b0;
      cyc = 0; hit = 0;
      while (!hit && cyc < 5000) begin
         if (go_a && row_a == 4 && col_a == 2 && fsel_a == 1) hit = 1;
         @(posedge clk); #1; cyc++;
      end
      chk("a_reached_4_2_1", hit, 1);
      rst_a = 1'b1;
      @(posedge clk); #1;
      chk_idle_a("midreset");
      snap = n_ov_a;
      rst_a = 1'b0;
      repeat (6) @(posedge clk);
      #1;
      chk("a_results_before_reset", snap, 103);
      chk("a_late_calc_dropped", n_ov_a, 103);
      chk("a_idle_after_reset", busy_a, 0);

      // Pass 3: clean restart from (0, 0, 0).
      er_a = 0; ec_a = 0; ef_a = 0; n_ov_a = 0; n_done_a = 0;
      start_a = 1'b1;
      @(posedge clk); #1;
      start_a = 1'b0;
      cyc = 0;
      while (!done_a && cyc < 5000) begin @(posedge clk); #1; cyc++; end
      chk("a_pass3_done_seen", done_a, 1);
      repeat (3) @(posedge clk);
      #1;
      chk("a_pass3_results", n_ov_a, 192);
      chk("a_pass3_done_count", n_done_a, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
